// File: rtl/sm_addsub_pipe_if.sv
// Handshake bundle for sm_addsub_pipe: operand/mode input side, result output side,
// and the overflow counter observation/clear.
interface sm_addsub_pipe_if #(
    parameter int BITS  = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [BITS-1:0]  in_a;
    logic [BITS-1:0]  in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [BITS-1:0]  out_res;
    logic             out_ovf;
    logic [CNT_W-1:0] ovf_cnt;
    logic             ovf_clr;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready, ovf_clr,
        input  in_ready, out_valid, out_res, out_ovf, ovf_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready, ovf_clr,
        output in_ready, out_valid, out_res, out_ovf, ovf_cnt
    );
endinterface

// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor with valid/ready flow control and a saturating
// overflow event counter. Define SM_ADDSUB_SAT_EN to clamp overflowing magnitudes instead of wrapping.
module sm_addsub_pipe #(
    parameter int BITS    = 16,
    parameter int FIX_BIT = 7,
    parameter int CNT_W   = 8
) (
    input logic            clk,
    input logic            rst_n,
    sm_addsub_pipe_if.slave bus
);
    localparam int MW = BITS - 1;
    localparam logic [MW-1:0] MAG_MAX = '1;

    // The binary point only affects interpretation, but it must lie inside the magnitude.
    if (FIX_BIT >= MW) begin : g_bad_fix_bit
        $error("FIX_BIT must be smaller than the magnitude width");
    end

    function automatic logic signed [BITS:0] to_tc(input logic [BITS-1:0] sm);
        logic signed [BITS:0] m;
        m = $signed({2'b00, sm[MW-1:0]});
        return sm[BITS-1] ? -m : m;
    endfunction

    logic                   s1_valid, s2_valid;
    logic signed [BITS+1:0] s1_sum;
    logic [BITS-1:0]        s2_res;
    logic                   s2_ovf;
    logic [CNT_W-1:0]       cnt;

    logic                   s1_adv, s2_adv;
    logic signed [BITS:0]   a_tc, b_tc, b_eff;
    logic signed [BITS+1:0] sum_d;
    logic [BITS+1:0]        abs_sum;
    logic [MW-1:0]          mag_d;
    logic                   ovf_d;
    logic                   sign_d;

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    // NOTE: every variable gets an unconditional assignment here, so no latch can be inferred.
    always_comb begin
        a_tc    = to_tc(bus.in_a);
        b_tc    = to_tc(bus.in_b);
        b_eff   = bus.in_sub ? -b_tc : b_tc;
        sum_d   = {a_tc[BITS], a_tc} + {b_eff[BITS], b_eff};

        abs_sum = s1_sum[BITS+1] ? -s1_sum : s1_sum;
        ovf_d   = (abs_sum[BITS+1:MW] != '0);
`ifdef SM_ADDSUB_SAT_EN
        mag_d   = ovf_d ? MAG_MAX : abs_sum[MW-1:0];
`else
        mag_d   = abs_sum[MW-1:0];
`endif
        // A zero magnitude is always reported as positive zero.
        sign_d  = s1_sum[BITS+1] && (mag_d != '0);
    end

    // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) s1_sum <= sum_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_ovf   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res <= {sign_d, mag_d};
                s2_ovf <= ovf_d;
            end
        end
    end

    // Clear has priority over a coincident overflow transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (bus.ovf_clr) begin
            cnt <= '0;
        end else if (s2_valid && bus.out_ready && s2_ovf && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_res   = s2_res;
    assign bus.out_ovf   = s2_ovf;
    assign bus.ovf_cnt   = cnt;
endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Scoreboard bench for sm_addsub_pipe: directed cases, flow-control stalls, reset in flight,
// counter saturation and randomized traffic against an integer reference model.
module tb_sm_addsub_pipe;
    localparam int BITS  = 16;
    localparam int CNT_W = 8;
    localparam int MAXM  = 2 ** (BITS - 1) - 1;

    typedef struct packed {
        logic [BITS-1:0] res;
        logic            ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;
    int   exp_cnt;
    exp_t sb[$];
    int   xfer_cyc[$];
    logic [BITS-1:0] last_res;
    logic            last_ovf;

    sm_addsub_pipe_if #(.BITS(BITS), .CNT_W(CNT_W)) bus ();

    sm_addsub_pipe #(.BITS(BITS), .FIX_BIT(7), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: signed integer arithmetic on the decoded values.
    function automatic exp_t model(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input logic sub);
        int av, bv, r, m, mag;
        exp_t e;
        av = a[BITS-1] ? -int'(a[BITS-2:0]) : int'(a[BITS-2:0]);
        bv = b[BITS-1] ? -int'(b[BITS-2:0]) : int'(b[BITS-2:0]);
        r  = sub ? av - bv : av + bv;
        m  = (r < 0) ? -r : r;
        e.ovf = (m > MAXM);
`ifdef SM_ADDSUB_SAT_EN
        mag = e.ovf ? MAXM : m;
`else
        mag = m % (MAXM + 1);
`endif
        e.res = {(r < 0) && (mag != 0), mag[BITS-2:0]};
        return e;
    endfunction

    function automatic logic [BITS-1:0] rand_sm();
        logic [BITS-1:0] v;
        v = BITS'($urandom);
        case ($urandom_range(0, 7))
            0:       v[BITS-2:0] = '0;
            1:       v[BITS-2:0] = '1;
            default: ;
        endcase
        return v;
    endfunction

    // Monitor: every output transfer pops the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got 0x%0h, expected no result", bus.out_res);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_res", 32'(bus.out_res), 32'(e.res));
                check("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
                last_res = bus.out_res;
                last_ovf = bus.out_ovf;
                xfer_cyc.push_back(cyc);
                if (e.ovf && exp_cnt < 2 ** CNT_W - 1) exp_cnt++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input logic sub);
        int t;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 1000) begin
            t++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            sb.push_back(model(a, b, sub));
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            t++;
            @(posedge clk);
        end
        idle(1);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int acc;
        logic [BITS-1:0] a, b;
        logic sub;
        tests = 0; fails = 0; exp_cnt = 0; cyc = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sub = 1'b0;
        bus.out_ready = 1'b1; bus.ovf_clr = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_res",   32'(bus.out_res),   32'd0);
        check("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
        check("rst_ovf_cnt",   32'(bus.ovf_cnt),   32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);

        // 1) subtract with latency check
        issue(16'h0180, 16'h80C0, 1'b1);
        check("lat_not_early", 32'(bus.out_valid), 32'd0);
        idle(1);
        check("lat_valid", 32'(bus.out_valid), 32'd1);
        check("sub_res", 32'(bus.out_res), 32'h0240);
        idle(1);

        // 2) add, including negative-zero cancellation
        issue(16'h0180, 16'h80C0, 1'b0);
        idle(2);
        check("add_res", 32'(last_res), 32'h00C0);
        issue(16'h8100, 16'h0100, 1'b0);
        idle(2);
        check("zero_res", 32'(last_res), 32'h0000);

        // 3) overflow, counter increment and clear
        issue(16'h7FFF, 16'h0001, 1'b0);
        idle(2);
        check("ovf_flag", 32'(last_ovf), 32'd1);
`ifdef SM_ADDSUB_SAT_EN
        check("ovf_res", 32'(last_res), 32'h7FFF);
`else
        check("ovf_res", 32'(last_res), 32'h0000);
`endif
        check("ovf_cnt_1", 32'(bus.ovf_cnt), 32'd1);
        bus.ovf_clr = 1'b1;
        idle(1);
        bus.ovf_clr = 1'b0;
        exp_cnt = 0;
        check("ovf_cnt_clr", 32'(bus.ovf_cnt), 32'd0);

        // 4) back-to-back stream
        xfer_cyc.delete();
        for (int i = 0; i < 8; i++) issue(rand_sm(), rand_sm(), 1'($urandom));
        drain();
        check("stream_count", 32'(xfer_cyc.size()), 32'd8);
        if (xfer_cyc.size() == 8)
            check("stream_consecutive", 32'(xfer_cyc[7] - xfer_cyc[0]), 32'd7);

        // 5) output stall while input keeps offering
        bus.out_ready = 1'b0;
        acc = 0;
        a = rand_sm(); b = rand_sm(); sub = 1'($urandom);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sub = sub;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(model(a, b, sub));
                acc++;
                @(posedge clk); #1;
                a = rand_sm(); b = rand_sm(); sub = 1'($urandom);
                bus.in_a = a; bus.in_b = b; bus.in_sub = sub;
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b0;
        check("stall_accepted", 32'(acc), 32'd2);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        drain();

        // 6) reset with two transactions in flight
        issue(16'h7FFF, 16'h7FFF, 1'b0);
        idle(2);
        bus.out_ready = 1'b0;
        issue(rand_sm(), rand_sm(), 1'b0);
        issue(rand_sm(), rand_sm(), 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_ovf_cnt",   32'(bus.ovf_cnt),   32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        sb.delete();
        exp_cnt = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        idle(5);
        check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);

        // Randomized traffic with random backpressure
        acc = 0;
        for (int i = 0; i < 400; i++) begin
            if (!bus.in_valid || acc != 0) begin
                a = rand_sm(); b = rand_sm(); sub = 1'($urandom);
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_a = a; bus.in_b = b; bus.in_sub = sub;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = (bus.in_valid && bus.in_ready) ? 1 : 0;
            if (acc != 0) sb.push_back(model(a, b, sub));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        check("rand_ovf_cnt", 32'(bus.ovf_cnt), 32'(exp_cnt));

        // Counter saturation
        for (int i = 0; i < 260; i++) issue(16'h7FFF, 16'h7FFF, 1'b0);
        drain();
        check("cnt_saturate", 32'(bus.ovf_cnt), 32'hFF);

        // Clear coinciding with an overflow transfer
        bus.out_ready = 1'b0;
        issue(16'h7FFF, 16'h0001, 1'b0);
        idle(1);
        bus.out_ready = 1'b1;
        bus.ovf_clr = 1'b1;
        idle(1);
        bus.ovf_clr = 1'b0;
        exp_cnt = 0;
        check("clr_wins", 32'(bus.ovf_cnt), 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
